spi_burst_master: RTL
=====================

# spi_burst_master

Master-side SPI sequencer for the board's FPGA register link. Two on-chip requesters share one SPI port; the block arbitrates round-robin and serialises each granted request into one chip-select frame. A frame is an 8-bit header (7-bit start address, then R/W bit) followed by 1..MAX_WORDS DWIDTH-bit words. The slave auto-increments the address per word, so no addresses follow the header. The block generates SCLK from spi_clk (SCLK = spi_clk/2) and returns read words to the owning requester.

## Interface
- DWIDTH, 16, word width; must match slave.
- ALINES, 7, address width; header = ALINES+1 = 8 bits; only 7 supported.
- MAX_WORDS, 16, max words per frame; LW = $clog2(MAX_WORDS).

Ports:
- spi_clk  in  1  block clock; all logic on rising edge.
- rst  in  1  reset rst, asynchronous, active-high.
- req  in  2  per-requester request level, held until done.
- req_rnw  in  2  1 = read, 0 = write.
- req_addr  in  2*ALINES  start address, requester i at [i*ALINES +: ALINES].
- req_len  in  2*LW  word count minus 1, requester i at [i*LW +: LW].
- wdata  in  2*DWIDTH  write word, requester i at [i*DWIDTH +: DWIDTH].
- gnt  out  2  one-hot grant, high for the whole frame.
- wd_ack  out  2  1-cycle pulse: current wdata word loaded; present next word within 2 cycles.
- rd_valid  out  2  1-cycle pulse: rd_data holds a new read word.
- rd_data  out  DWIDTH  last read word, held until the next word.
- done  out  2  1-cycle pulse at frame end.
- sclk  out  1  SPI clock, idle low.
- cs_n  out  1  chip select, idle high.
- mosi  out  1  serial out, MSB first.
- miso  in  1  serial in, MSB first.

## Operation
- States: IDLE, HDR, DATA, HOLD, GAP.
- IDLE: if any req, grant it. If both req, grant the requester not served last. After reset, requester 0 wins a tie.
- On grant, latch addr, rnw and len. gnt is set and held. Later changes on req or the latched fields are ignored until done.
- Each bit takes 2 spi_clk cycles:
  - phase 0: sclk=0, mosi updated.
  - phase 1: sclk=1; miso sampled at the end of phase 1.
- HDR: 8 bits: addr[6]..addr[0], then rnw.
- DATA: len+1 words.
  - Write: the word is loaded into the shift register in its first phase-0 cycle, and wd_ack[g] pulses that same cycle.
  - Read: mosi=0. The block shifts in miso. After the LSB is sampled, it updates rd_data and pulses rd_valid[g] on the next cycle.
- HOLD: 1 cycle, sclk=0, cs_n=0.
- Then cs_n=1, gnt=0 and done[g] pulses, all in the same cycle.
- GAP: cs_n high for 2 cycles minimum, then IDLE.
- Word counter is LW+1 bits wide. len=MAX_WORDS-1 gives MAX_WORDS words with no wrap. Address wrap is the slave's concern.

## Timing
- Reset values: gnt=0, wd_ack=0, rd_valid=0, rd_data=0, done=0, sclk=0, cs_n=1, mosi=0. Arbiter pointer = requester 1 "last served".
- Cycle 0: req seen in IDLE. Cycle 1: gnt=1, cs_n=0, mosi=addr[6], sclk=0. First sclk rise is at cycle 2.
- cs_n low duration = 2*(8+N*DWIDTH)+1 cycles, where N = len+1.
- Minimum done-to-next-frame cs_n fall: 3 cycles.
- Reset mid-frame: all outputs return to reset values immediately; no done pulse.

## Test plan
- Reset: assert rst mid-idle and again mid-DATA -> cs_n=1 and sclk=0 within the same cycle, all pulses 0, no done.
- Single write: req0, addr 7'h15, len 0, wdata 16'hA55A -> mosi 0010101_0 then A55A. cs_n low 49 cycles. Exactly one wd_ack[0] and one done[0].
- Single read: req1, addr 7'h03, rnw 1. miso model returns 16'h1234 -> header 00000111; one rd_valid[1] with rd_data=16'h1234; done[1].
- Burst write: len 3, words 1111/2222/3333/4444 -> 4 wd_ack[0] pulses 32 cycles apart. mosi carries all words in order. cs_n low 145 cycles.
- Contention: req0 and req1 asserted together after reset -> gnt 01 first, then 10 no earlier than 3 cycles after done[0]. Repeat both -> order 0, 1, 0, 1 alternates.
- Max burst read: len=MAX_WORDS-1 -> 16 rd_valid pulses, then done. Requester changing req_addr mid-frame has no effect.

Source files
------------

// File: rtl/spi_burst_master.sv
// SPI burst master: round-robin arbitration between two requesters and
// serialisation of each grant into one chip-select frame (header + words).
module spi_burst_master #(
    parameter  int unsigned DWIDTH    = 16,
    parameter  int unsigned ALINES    = 7,
    parameter  int unsigned MAX_WORDS = 16,
    localparam int unsigned LW        = $clog2(MAX_WORDS)
) (
    input  logic                  spi_clk,
    input  logic                  rst,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_req_rnw,
    input  logic [2*ALINES-1:0]   i_req_addr,
    input  logic [2*LW-1:0]       i_req_len,
    input  logic [2*DWIDTH-1:0]   i_wdata,
    output logic [1:0]            o_gnt,
    output logic [1:0]            o_wd_ack,
    output logic [1:0]            o_rd_valid,
    output logic [DWIDTH-1:0]     o_rd_data,
    output logic [1:0]            o_done,
    output logic                  o_sclk,
    output logic                  o_cs_n,
    output logic                  o_mosi,
    input  logic                  i_miso
);

    localparam int unsigned HW = ALINES + 1;
    localparam int unsigned BW = $clog2(DWIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_HOLD,
        S_GAP
    } state_t;

    state_t              r_state, w_state_nx;
    logic                r_phase, w_phase_nx;
    logic [BW-1:0]       r_bit, w_bit_nx;
    logic [LW:0]         r_word, w_word_nx;
    logic [DWIDTH-1:0]   r_shift, w_shift_nx;
    logic                r_g, w_g_nx;
    logic                r_rnw, w_rnw_nx;
    logic [LW-1:0]       r_len, w_len_nx;
    logic                r_last, w_last_nx;
    logic                r_gap, w_gap_nx;
    logic [DWIDTH-1:0]   r_rd_data, w_rd_data_nx;
    logic [1:0]          r_gnt, w_gnt_nx;
    logic [1:0]          r_wd_ack, w_wd_ack_nx;
    logic [1:0]          r_rd_valid, w_rd_valid_nx;
    logic [1:0]          r_done, w_done_nx;
    logic                r_sclk, w_sclk_nx;
    logic                r_cs_n, w_cs_n_nx;
    logic                r_mosi, w_mosi_nx;
    logic                w_sel;

    logic [ALINES-1:0]   w_addr  [2];
    logic [LW-1:0]       w_len   [2];
    logic [DWIDTH-1:0]   w_wdata [2];

    // Split the flattened per-requester buses.
    for (genvar i = 0; i < 2; i++) begin : g_unpack
        assign w_addr[i]  = i_req_addr[i*ALINES +: ALINES];
        assign w_len[i]   = i_req_len[i*LW +: LW];
        assign w_wdata[i] = i_wdata[i*DWIDTH +: DWIDTH];
    end

    // On a tie, serve the requester that was not served last.
    assign w_sel = (&i_req) ? ~r_last : i_req[1];

    // State register.
    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Next-state, datapath and next-output logic; outputs describe the coming cycle.
    always_comb begin
        w_state_nx    = r_state;
        w_phase_nx    = r_phase;
        w_bit_nx      = r_bit;
        w_word_nx     = r_word;
        w_shift_nx    = r_shift;
        w_g_nx        = r_g;
        w_rnw_nx      = r_rnw;
        w_len_nx      = r_len;
        w_last_nx     = r_last;
        w_gap_nx      = r_gap;
        w_rd_data_nx  = r_rd_data;
        w_gnt_nx      = r_gnt;
        w_wd_ack_nx   = '0;
        w_rd_valid_nx = '0;
        w_done_nx     = '0;
        w_sclk_nx     = 1'b0;
        w_cs_n_nx     = r_cs_n;
        w_mosi_nx     = r_mosi;
        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_state_nx = S_HDR;
                    w_phase_nx = 1'b0;
                    w_bit_nx   = '0;
                    w_g_nx     = w_sel;
                    w_last_nx  = w_sel;
                    w_rnw_nx   = i_req_rnw[w_sel];
                    w_len_nx   = w_len[w_sel];
                    w_shift_nx = '0;
                    w_shift_nx[DWIDTH-1 -: HW] = {w_addr[w_sel], i_req_rnw[w_sel]};
                    w_gnt_nx   = w_sel ? 2'b10 : 2'b01;
                    w_cs_n_nx  = 1'b0;
                    w_mosi_nx  = w_addr[w_sel][ALINES-1];
                end
            end
            S_HDR: begin
                if (!r_phase) begin
                    w_phase_nx = 1'b1;
                    w_sclk_nx  = 1'b1;
                end else begin
                    w_phase_nx = 1'b0;
                    w_shift_nx = {r_shift[DWIDTH-2:0], i_miso};
                    if (r_bit == BW'(HW-1)) begin
                        w_state_nx = S_DATA;
                        w_bit_nx   = '0;
                        w_word_nx  = '0;
                        if (!r_rnw) begin
                            w_shift_nx       = w_wdata[r_g];
                            w_wd_ack_nx[r_g] = 1'b1;
                            w_mosi_nx        = w_wdata[r_g][DWIDTH-1];
                        end else begin
                            w_mosi_nx = 1'b0;
                        end
                    end else begin
                        w_bit_nx  = r_bit + 1'b1;
                        w_mosi_nx = w_shift_nx[DWIDTH-1];
                    end
                end
            end
            S_DATA: begin
                if (!r_phase) begin
                    w_phase_nx = 1'b1;
                    w_sclk_nx  = 1'b1;
                end else begin
                    w_phase_nx = 1'b0;
                    w_shift_nx = {r_shift[DWIDTH-2:0], i_miso};
                    w_mosi_nx  = r_rnw ? 1'b0 : w_shift_nx[DWIDTH-1];
                    if (r_bit == BW'(DWIDTH-1)) begin
                        w_bit_nx = '0;
                        if (r_rnw) begin
                            w_rd_data_nx       = w_shift_nx;
                            w_rd_valid_nx[r_g] = 1'b1;
                        end
                        if (r_word == (LW+1)'(r_len)) begin
                            w_state_nx = S_HOLD;
                            w_mosi_nx  = 1'b0;
                        end else begin
                            w_word_nx = r_word + 1'b1;
                            if (!r_rnw) begin
                                w_shift_nx       = w_wdata[r_g];
                                w_wd_ack_nx[r_g] = 1'b1;
                                w_mosi_nx        = w_wdata[r_g][DWIDTH-1];
                            end
                        end
                    end else begin
                        w_bit_nx = r_bit + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                w_state_nx     = S_GAP;
                w_gap_nx       = 1'b0;
                w_cs_n_nx      = 1'b1;
                w_gnt_nx       = '0;
                w_done_nx[r_g] = 1'b1;
            end
            S_GAP: begin
                if (r_gap) w_state_nx = S_IDLE;
                else       w_gap_nx   = 1'b1;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            r_phase    <= 1'b0;
            r_bit      <= '0;
            r_word     <= '0;
            r_shift    <= '0;
            r_g        <= 1'b0;
            r_rnw      <= 1'b0;
            r_len      <= '0;
            r_last     <= 1'b1;
            r_gap      <= 1'b0;
            r_rd_data  <= '0;
            r_gnt      <= '0;
            r_wd_ack   <= '0;
            r_rd_valid <= '0;
            r_done     <= '0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_phase    <= w_phase_nx;
            r_bit      <= w_bit_nx;
            r_word     <= w_word_nx;
            r_shift    <= w_shift_nx;
            r_g        <= w_g_nx;
            r_rnw      <= w_rnw_nx;
            r_len      <= w_len_nx;
            r_last     <= w_last_nx;
            r_gap      <= w_gap_nx;
            r_rd_data  <= w_rd_data_nx;
            r_gnt      <= w_gnt_nx;
            r_wd_ack   <= w_wd_ack_nx;
            r_rd_valid <= w_rd_valid_nx;
            r_done     <= w_done_nx;
            r_sclk     <= w_sclk_nx;
            r_cs_n     <= w_cs_n_nx;
            r_mosi     <= w_mosi_nx;
        end
    end

    assign o_gnt      = r_gnt;
    assign o_wd_ack   = r_wd_ack;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_done     = r_done;
    assign o_sclk     = r_sclk;
    assign o_cs_n     = r_cs_n;
    assign o_mosi     = r_mosi;

endmodule
